// File: rtl/fir_capture_buffer_if.sv
// fir_capture_buffer_if: capture/readout bus; peak_out present only with CAP_PEAK_EN defined
interface fir_capture_buffer_if #(
  parameter int N  = 16,
  parameter int AW = 5
);
  logic [N-1:0] data_in;
  logic         arm;
  logic         start_read;
  logic         rd_ready;
  logic [N-1:0] rd_data;
  logic         rd_valid;
  logic         rd_last;
  logic         busy;
  logic         done;
  logic [AW:0]  count;
`ifdef CAP_PEAK_EN
  logic [N-1:0] peak_out;
  modport master (output data_in, arm, start_read, rd_ready,
                  input rd_data, rd_valid, rd_last, busy, done, count, peak_out);
  modport slave  (input data_in, arm, start_read, rd_ready,
                  output rd_data, rd_valid, rd_last, busy, done, count, peak_out);
`else
  modport master (output data_in, arm, start_read, rd_ready,
                  input rd_data, rd_valid, rd_last, busy, done, count);
  modport slave  (input data_in, arm, start_read, rd_ready,
                  output rd_data, rd_valid, rd_last, busy, done, count);
`endif
endinterface

// File: rtl/fir_capture_buffer.sv
// fir_capture_buffer: one-shot DEPTH-sample capture of a FIR output stream with valid/ready readout.
// Optional CAP_PEAK_EN adds an unsigned peak-of-capture output.
module fir_capture_buffer #(
  parameter int N     = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input logic                clk,
  input logic                reset,
  fir_capture_buffer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CAPTURE, FULL, READOUT} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          we;
  logic [N-1:0]  mem_q [DEPTH];
`ifdef CAP_PEAK_EN
  logic [N-1:0]  peak_q, peak_d;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
`ifdef CAP_PEAK_EN
      peak_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef CAP_PEAK_EN
      peak_q   <= peak_d;
`endif
    end
  end
  // storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_ptr_q] <= bus.data_in;
  end
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    we       = 1'b0;
`ifdef CAP_PEAK_EN
    peak_d   = peak_q;
`endif
    unique case (state_q)
      IDLE, FULL: begin
        if (bus.arm) begin
          state_d  = CAPTURE;
          wr_ptr_d = '0;
          count_d  = '0;
`ifdef CAP_PEAK_EN
          peak_d   = '0;
`endif
        end else if (state_q == FULL && bus.start_read) begin
          state_d  = READOUT;
          rd_ptr_d = '0;
        end
      end
      CAPTURE: begin
        we       = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        count_d  = count_q + 1'b1;
        state_d  = (wr_ptr_q == {AW{1'b1}}) ? FULL : CAPTURE;
`ifdef CAP_PEAK_EN
        peak_d   = (bus.data_in > peak_q) ? bus.data_in : peak_q;
`endif
      end
      READOUT: begin
        if (bus.rd_ready) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          state_d  = (rd_ptr_q == {AW{1'b1}}) ? IDLE : READOUT;
          count_d  = (rd_ptr_q == {AW{1'b1}}) ? '0 : count_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.rd_valid = (state_q == READOUT);
  assign bus.rd_data  = bus.rd_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.rd_last  = bus.rd_valid && (rd_ptr_q == {AW{1'b1}});
  assign bus.busy     = (state_q == CAPTURE) || (state_q == READOUT);
  assign bus.done     = (state_q == FULL);
  assign bus.count    = count_q;
`ifdef CAP_PEAK_EN
  assign bus.peak_out = peak_q;
`endif
endmodule

// File: doc/fir_capture_buffer.md
FIR_CAPTURE_BUFFER -- requirements
Module: fir_capture_buffer

Interface
REQ-001 The block SHALL have parameter N, default 16, giving the sample width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, giving the capture depth in samples; DEPTH is a power of two.
REQ-003 The block SHALL have parameter AW, default 5, giving the address width, equal to log2(DEPTH).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port data_in, input, N bits: FIR filter output sample, one new sample every clk.
REQ-007 The block SHALL have port arm, input, 1 bit: single-cycle request to start a capture.
REQ-008 The block SHALL have port start_read, input, 1 bit: single-cycle request to begin readout of a full buffer.
REQ-009 The block SHALL have port rd_ready, input, 1 bit: consumer can accept rd_data this cycle.
REQ-010 The block SHALL have port rd_data, output, N bits: the sample currently presented for readout.
REQ-011 The block SHALL have port rd_valid, output, 1 bit: rd_data is valid.
REQ-012 The block SHALL have port rd_last, output, 1 bit: the presented sample is entry DEPTH-1.
REQ-013 The block SHALL have port busy, output, 1 bit: high in CAPTURE and READOUT.
REQ-014 The block SHALL have port done, output, 1 bit: high in FULL.
REQ-015 The block SHALL have port count, output, AW+1 bits: number of samples stored in the current capture, 0..DEPTH.

Function
REQ-016 The block SHALL implement exactly four states, IDLE, CAPTURE, FULL and READOUT, with storage of DEPTH x N bits.
REQ-017 In IDLE, arm=1 SHALL move the block to CAPTURE on the next edge and clear wr_ptr and count to 0.
REQ-018 In CAPTURE, each edge SHALL write data_in to mem[wr_ptr] and increment wr_ptr and count; the first stored sample is the one present on the edge after arm is sampled.
REQ-019 After exactly DEPTH writes, the block SHALL enter FULL with count=DEPTH; wr_ptr wraps to 0 and no further writes occur.
REQ-020 In CAPTURE and READOUT, arm and start_read SHALL be ignored.
REQ-021 In FULL, arm=1 SHALL restart a capture as described in REQ-017 and overwrite the buffer.
REQ-022 In FULL, start_read=1 with arm=0 SHALL move the block to READOUT with rd_ptr=0; if arm and start_read are both high, arm wins.
REQ-023 In READOUT, rd_valid SHALL be 1 and rd_data SHALL equal mem[rd_ptr] in the same cycle, with zero latency from rd_ptr.
REQ-024 A transfer SHALL occur on an edge where rd_valid=1 and rd_ready=1; rd_ptr increments by one per transfer, and rd_data is held stable while rd_ready=0.
REQ-025 rd_last SHALL be 1 exactly when READOUT is active and rd_ptr=DEPTH-1.
REQ-026 The transfer with rd_last=1 SHALL return the block to IDLE with count=0; outside READOUT, rd_valid=0, rd_last=0 and rd_data=0.
REQ-027 In IDLE, start_read SHALL be ignored.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, set wr_ptr, rd_ptr, count, busy, done, rd_valid, rd_last and rd_data to 0, and abort any capture or readout in progress.
REQ-029 Memory contents SHALL NOT be cleared by reset, and no test depends on their value after reset.
REQ-030 The first state change after reset deasserts SHALL occur on the first rising clk edge at which reset=1.

Configuration
REQ-031 With macro CAP_PEAK_EN defined, the block SHALL add output peak_out, N bits, unsigned, holding the maximum data_in stored during the current capture, updated on the same edge as the write; it is cleared to 0 by reset and by arm acceptance, and held through FULL and READOUT.
REQ-032 Without CAP_PEAK_EN, port peak_out and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-033 Reset, then arm for 1 cycle while data_in=0..31 ramps one per clk -> busy for 32 cycles, then done=1 and count=32; start_read with rd_ready=1 yields rd_data=0..31 in order, rd_last only on 31, then IDLE.
REQ-034 During READOUT, toggle rd_ready 1,0,0,1,... -> no sample is lost or duplicated, and rd_data is stable while rd_ready=0.
REQ-035 Pulse reset=0 mid-capture at count=10 -> IDLE immediately with count=0 and busy=0; a following arm performs a clean 32-sample capture.
REQ-036 In FULL, assert arm and start_read together -> a new capture starts and readout does not; arm in CAPTURE and start_read in IDLE have no effect.
REQ-037 With CAP_PEAK_EN defined, capture samples including 16'hFFF0 -> peak_out=16'hFFF0 in FULL; a re-arm clears peak_out to 0.
